// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core control sequencer:
// opcodes, halt encoding and FSM state type.
package core_sequencer_pkg;

    localparam logic [2:0] OP_LT  = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_LD  = 3'd5;
    localparam logic [2:0] OP_ST  = 3'd6;
    localparam logic [2:0] OP_BR  = 3'd7;

    localparam logic [2:0] HALT_R1 = 3'd7;
    localparam logic [2:0] HALT_R2 = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } seq_state_t;

    function automatic logic is_halt(
        input logic [2:0] op,
        input logic [2:0] r1,
        input logic [2:0] r2
    );
        return (op == OP_BR) && (r1 == HALT_R1) && (r2 == HALT_R2);
    endfunction

    function automatic logic is_mem(input logic [2:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/core_sequencer_watchdog.sv
// Run-time guards: memory wait counter with timeout,
// and retired-instruction limit compare.
module seq_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int MAX_INSTR   = 4096,
    parameter int CNT_BITS    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_mem,
    input  logic [CNT_BITS-1:0] instr_count,
    output logic                timeout,
    output logic                limit
);

    localparam int WW = $clog2(MEM_TIMEOUT) + 1;

    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clock) begin
        if (reset || !in_mem) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign timeout = in_mem && (wait_cnt == WW'(MEM_TIMEOUT - 1));
    // The retire in flight makes the count reach MAX_INSTR.
    assign limit = (instr_count == CNT_BITS'(MAX_INSTR - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the 8-bit core datapath:
// fetch/decode/exec/mem/wb strobes, memory handshake, run guards.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int MAX_INSTR   = 4096,
    parameter int CNT_BITS    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          instr_op,
    input  logic [2:0]          instr_r1,
    input  logic [2:0]          instr_r2,
    input  logic                alu_jump,
    input  logic                mem_ready,
    output logic                pc_clear,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                ir_load,
    output logic                reg_write,
    output logic                reg_src_mem,
    output logic                mem_req,
    output logic                mem_write,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CNT_BITS-1:0] cycle_count,
    output logic [CNT_BITS-1:0] instr_count
);

    seq_state_t state;
    seq_state_t state_nx;

    logic st_op;
    logic retire;
    logic timeout;
    logic limit;
    logic abort;

    assign st_op  = (instr_op == OP_ST);
    assign retire = ((state == EXEC) && !is_mem(instr_op))
                  || ((state == MEM) && mem_ready && st_op)
                  || (state == WB);
    // A ready in the last allowed wait cycle still completes.
    assign abort  = (retire && limit)
                  || ((state == MEM) && !mem_ready && timeout);

    seq_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .MAX_INSTR   (MAX_INSTR),
        .CNT_BITS    (CNT_BITS)
    ) u_watchdog (
        .clock       (clock),
        .reset       (reset),
        .in_mem      (state == MEM),
        .instr_count (instr_count),
        .timeout     (timeout),
        .limit       (limit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = DECODE;
            DECODE:  state_nx = is_halt(instr_op, instr_r1, instr_r2)
                              ? HALT : EXEC;
            EXEC:    state_nx = is_mem(instr_op) ? MEM : FETCH;
            MEM: begin
                if (mem_ready) state_nx = st_op ? FETCH : WB;
            end
            WB:      state_nx = FETCH;
            HALT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = HALT;
    end

    always_comb begin
        pc_clear    = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        ir_load     = 1'b0;
        reg_write   = 1'b0;
        reg_src_mem = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        unique case (state)
            IDLE:  pc_clear = start;
            FETCH: ir_load = 1'b1;
            EXEC: begin
                if (instr_op == OP_BR) begin
                    pc_load = alu_jump;
                    pc_inc  = !alu_jump;
                end else if (!is_mem(instr_op)) begin
                    reg_write = 1'b1;
                    pc_inc    = 1'b1;
                end
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_write = st_op;
                pc_inc    = mem_ready && st_op;
            end
            WB: begin
                reg_write   = 1'b1;
                reg_src_mem = 1'b1;
                pc_inc      = 1'b1;
            end
            HALT:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
            error       <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                cycle_count <= '0;
                instr_count <= '0;
                error       <= 1'b0;
            end
        end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_BITS'(1);
            if (retire) instr_count <= instr_count + CNT_BITS'(1);
            if (abort) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-instruction cycle model
// driven with directed and random programs.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    localparam int MAXI = 4;
    localparam int TMO  = 16;

    localparam logic [9:0] E_CLR = 10'h200;
    localparam logic [9:0] E_INC = 10'h100;
    localparam logic [9:0] E_PCL = 10'h080;
    localparam logic [9:0] E_IR  = 10'h040;
    localparam logic [9:0] E_RW  = 10'h020;
    localparam logic [9:0] E_SRC = 10'h010;
    localparam logic [9:0] E_REQ = 10'h008;
    localparam logic [9:0] E_WR  = 10'h004;
    localparam logic [9:0] E_BSY = 10'h002;
    localparam logic [9:0] E_DN  = 10'h001;

    typedef struct {
        logic [2:0] op;
        logic [2:0] r1;
        logic [2:0] r2;
        logic       jump;
        int         lat;
    } instr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  instr_op;
    logic [2:0]  instr_r1;
    logic [2:0]  instr_r2;
    logic        alu_jump;
    logic        mem_ready;
    logic        pc_clear;
    logic        pc_inc;
    logic        pc_load;
    logic        ir_load;
    logic        reg_write;
    logic        reg_src_mem;
    logic        mem_req;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;

    int     nvec = 0;
    int     nerr = 0;
    int     m_cyc = 0;
    int     m_ret = 0;
    bit     m_err = 1'b0;
    bit     live = 1'b0;
    instr_t prog[$];

    wire [9:0] outs = {pc_clear, pc_inc, pc_load, ir_load, reg_write,
                       reg_src_mem, mem_req, mem_write, busy, done};

    always #5 clock = ~clock;

    core_sequencer #(
        .MEM_TIMEOUT (TMO),
        .MAX_INSTR   (MAXI),
        .CNT_BITS    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .instr_op    (instr_op),
        .instr_r1    (instr_r1),
        .instr_r2    (instr_r2),
        .alu_jump    (alu_jump),
        .mem_ready   (mem_ready),
        .pc_clear    (pc_clear),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .ir_load     (ir_load),
        .reg_write   (reg_write),
        .reg_src_mem (reg_src_mem),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock: check this cycle, then advance the model.
    task automatic step(input string tag, input logic [9:0] exp,
                        input bit ret);
        @(negedge clock);
        chk({tag, ".out"}, 32'(outs), 32'(exp));
        chk({tag, ".err"}, 32'(error), 32'(m_err));
        chk({tag, ".cyc"}, 32'(cycle_count), 32'(m_cyc));
        chk({tag, ".ret"}, 32'(instr_count), 32'(m_ret));
        @(posedge clock);
        if (exp[1] && m_cyc < 65535) m_cyc++;
        if (ret) m_ret++;
        #1;
        start     = live ? 1'($urandom) : 1'b0;
        alu_jump  = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    function automatic instr_t mk(input logic [2:0] op, input logic [2:0] r1,
                                  input logic [2:0] r2, input logic j,
                                  input int lat);
        instr_t t;
        t.op = op;
        t.r1 = r1;
        t.r2 = r2;
        t.jump = j;
        t.lat = lat;
        return t;
    endfunction

    task automatic run_prog(input string nm);
        bit fin;
        bit aborted;
        fin = 1'b0;
        aborted = 1'b0;
        start = 1'b1;
        step({nm, ".start"}, E_CLR, 1'b0);
        m_cyc = 0;
        m_ret = 0;
        m_err = 1'b0;
        live  = 1'b1;
        for (int i = 0; i < prog.size() && !fin; i++) begin
            instr_t ins;
            bit ret;
            bit st;
            bit rdy;
            ins = prog[i];
            ret = 1'b0;
            st  = (ins.op == OP_ST);
            {instr_op, instr_r1, instr_r2} = 9'($urandom);
            step({nm, ".fetch"}, E_IR | E_BSY, 1'b0);
            instr_op = ins.op;
            instr_r1 = ins.r1;
            instr_r2 = ins.r2;
            step({nm, ".decode"}, E_BSY, 1'b0);
            if (ins.op == 3'd7 && ins.r1 == 3'd7 && ins.r2 == 3'd7) break;
            if (ins.op == OP_LD || st) begin
                step({nm, ".exec"}, E_BSY, 1'b0);
                for (int k = 0; k < TMO; k++) begin
                    rdy = (k == ins.lat);
                    mem_ready = rdy;
                    if (ins.lat == -2 && k == 2) begin
                        reset = 1'b1;
                        live = 1'b0;
                    end
                    step({nm, ".mem"},
                         E_REQ | E_BSY | (st ? E_WR : 10'h0)
                         | ((st && rdy) ? E_INC : 10'h0), st && rdy);
                    if (reset) begin
                        reset = 1'b0;
                        m_cyc = 0;
                        m_ret = 0;
                        m_err = 1'b0;
                        fin = 1'b1;
                        aborted = 1'b1;
                        break;
                    end
                    if (rdy) begin
                        if (!st) step({nm, ".wb"},
                                      E_RW | E_SRC | E_INC | E_BSY, 1'b1);
                        ret = 1'b1;
                        break;
                    end
                    if (k == TMO - 1) begin
                        m_err = 1'b1;
                        fin = 1'b1;
                    end
                end
            end else if (ins.op == OP_BR) begin
                alu_jump = ins.jump;
                step({nm, ".br"},
                     (ins.jump ? E_PCL : E_INC) | E_BSY, 1'b1);
                ret = 1'b1;
            end else begin
                step({nm, ".alu"}, E_RW | E_INC | E_BSY, 1'b1);
                ret = 1'b1;
            end
            if (ret && m_ret == MAXI) begin
                m_err = 1'b1;
                fin = 1'b1;
            end
        end
        live = 1'b0;
        if (aborted) begin
            step({nm, ".after_rst"}, 10'h0, 1'b0);
        end else begin
            step({nm, ".halt"}, E_BSY | E_DN, 1'b0);
            step({nm, ".idle"}, 10'h0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        {instr_op, instr_r1, instr_r2} = 9'h0;
        alu_jump = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        step("reset", 10'h0, 1'b0);

        prog.delete();
        prog.push_back(mk(OP_ADD, 3'd1, 3'd2, 1'b0, 0));
        prog.push_back(mk(OP_SUB, 3'd3, 3'd4, 1'b0, 0));
        prog.push_back(mk(OP_BR, 3'd7, 3'd7, 1'b0, 0));
        run_prog("addsub");
        chk("addsub.cycles", 32'(cycle_count), 32'd9);
        chk("addsub.retired", 32'(instr_count), 32'd2);

        prog.delete();
        prog.push_back(mk(OP_LD, 3'd1, 3'd2, 1'b0, 3));
        prog.push_back(mk(OP_BR, 3'd7, 3'd7, 1'b0, 0));
        run_prog("ld");
        chk("ld.retired", 32'(instr_count), 32'd1);

        prog.delete();
        prog.push_back(mk(OP_BR, 3'd0, 3'd1, 1'b1, 0));
        prog.push_back(mk(OP_BR, 3'd0, 3'd1, 1'b0, 0));
        prog.push_back(mk(OP_BR, 3'd7, 3'd7, 1'b0, 0));
        run_prog("br");

        prog.delete();
        prog.push_back(mk(OP_ST, 3'd2, 3'd3, 1'b0, -1));
        run_prog("st_tmo");
        chk("st_tmo.error", 32'(error), 32'd1);

        prog.delete();
        prog.push_back(mk(OP_LD, 3'd2, 3'd3, 1'b0, -2));
        run_prog("mem_rst");
        prog.delete();
        prog.push_back(mk(OP_XOR, 3'd2, 3'd3, 1'b0, 0));
        prog.push_back(mk(OP_BR, 3'd7, 3'd7, 1'b0, 0));
        run_prog("post_rst");

        prog.delete();
        for (int i = 0; i < 5; i++)
            prog.push_back(mk(OP_ADD, 3'd1, 3'd1, 1'b0, 0));
        run_prog("limit");
        chk("limit.retired", 32'(instr_count), 32'd4);
        chk("limit.error", 32'(error), 32'd1);

        for (int n = 0; n < 40; n++) begin
            int len;
            len = int'($urandom_range(1, 5));
            prog.delete();
            for (int i = 0; i < len; i++)
                prog.push_back(mk(3'($urandom), 3'($urandom), 3'($urandom),
                                  1'($urandom),
                                  int'($urandom_range(0, 17))));
            prog.push_back(mk(OP_BR, 3'd7, 3'd7, 1'b0, 0));
            run_prog("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM that sequences the 8-bit core datapath: PC, instruction memory, register file, ALU and data memory.
- Splits each 9-bit instruction (3-bit op, 3-bit reg1, 3-bit reg2) into FETCH/DECODE/EXEC/MEM/WB steps.
- Generates all datapath strobes and runs a req/ready handshake to data memory.
- Provides start/done program control with run-time guards: memory timeout and instruction limit.

Parameters:
- MEM_TIMEOUT, 16: max cycles in MEM waiting for mem_ready before error abort.
- MAX_INSTR, 4096: retired-instruction limit before error abort.
- CNT_BITS, 16: width of cycle_count and instr_count.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin program at PC 0; sampled in IDLE only
- instr_op  in  3  opcode field of current instruction
- instr_r1  in  3  reg1 field
- instr_r2  in  3  reg2 field
- alu_jump  in  1  ALU branch-taken flag, valid in EXEC
- mem_ready  in  1  data memory completes the access this cycle
- pc_clear  out  1  zero the PC
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= branch target
- ir_load  out  1  latch instruction fields
- reg_write  out  1  register file write enable
- reg_src_mem  out  1  write-data mux select: 1 = memory data, 0 = ALU result
- mem_req  out  1  data memory request
- mem_write  out  1  store qualifier, valid with mem_req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky abort flag
- cycle_count  out  CNT_BITS  cycles since start
- instr_count  out  CNT_BITS  retired instructions

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; counters 0; error 0. Reset applies mid-operation too, including in MEM with mem_req high: mem_req drops the next cycle and the pending access is abandoned.
- IDLE: if start=1, pulse pc_clear, clear counters and error, go to FETCH. start in any other state is ignored.
- FETCH: ir_load=1 for one cycle, then DECODE.
- DECODE: HALT encoding (op=OP_BR, r1=7, r2=7) goes to HALT without retiring; otherwise go to EXEC.
- EXEC, ALU ops (OP_LT, OP_ADD, OP_SUB, OP_XOR, OP_SHL): reg_write=1, pc_inc=1, retire, go to FETCH.
- EXEC, OP_LD or OP_ST: go to MEM; no strobes.
- EXEC, OP_BR: Mealy output on alu_jump. Taken gives pc_load=1; not taken gives pc_inc=1. Either way retire and go to FETCH. pc_load and pc_inc are never both high.
- MEM: mem_req=1 every cycle; mem_write=1 for OP_ST.
  - A wait counter starts at 0 on entry.
  - mem_ready=1 with OP_LD goes to WB.
  - mem_ready=1 with OP_ST gives pc_inc=1, retire, go to FETCH.
  - If the wait counter reaches MEM_TIMEOUT-1 without ready, set error and go to HALT.
  - mem_ready outside MEM is ignored.
- WB: reg_write=1, reg_src_mem=1, pc_inc=1, retire, go to FETCH.
- Retire: instr_count increments. If the new value equals MAX_INSTR, set error and go to HALT instead of FETCH.
- HALT: done=1 for exactly one cycle, then IDLE. error holds until the next start or reset.
- cycle_count: increments every cycle while busy, saturates at all-ones, holds after done.
- Cycle costs:
  - ALU op and BR: 3 cycles each.
  - ST: 3 + wait cycles + 1.
  - LD: ST cost + 1 (WB).
  - HALT instruction: FETCH, DECODE, HALT.
- At most one of reg_write, mem_req, pc_clear is high in any cycle.

Decomposition:
- Shared package (definitions): opcode constants OP_LT=0, OP_ADD=1, OP_SUB=2, OP_XOR=3, OP_SHL=4, OP_LD=5, OP_ST=6, OP_BR=7.
- Same package: enum seq_state_t {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT}; HALT_R1/HALT_R2 = 7.
- One sub-module, seq_watchdog: holds the MEM wait counter and the instr_count limit compare, with timeout/limit outputs. The FSM and strobe decode stay in core_sequencer.

Test Plan:
- Program ADD, SUB, HALT, with start pulsed once. Required: reg_write high on cycles 3 and 6 after start, done on cycle 9, instr_count=2, cycle_count=9, error=0.
- LD with mem_ready asserted 3 cycles after MEM entry. Required: mem_req high 4 cycles, then a WB cycle with reg_write=1 and reg_src_mem=1, then pc_inc; instr_count increments once.
- BR run twice, alu_jump=1 then 0. Required: first gives pc_load=1 with pc_inc=0; second gives pc_inc=1 with pc_load=0.
- ST with mem_ready held 0. Required: after 16 MEM cycles, error=1 and done pulse; mem_write=1 throughout MEM; then IDLE with busy=0.
- Reset asserted during MEM with mem_req=1. Required: next cycle all outputs 0, state IDLE, counters 0; a subsequent start runs normally.
- MAX_INSTR=4, loop of ALU ops with no HALT. Required: done with error=1 right after the 4th retire, instr_count=4; start asserted while busy has no effect.
